// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Execute stage of a five-stage RV32I pipeline. Selects forwarded operands,
// runs the ALU, resolves branches/jumps (redirect returned to fetch in the
// same cycle), holds the execute/memory pipeline register and counts the
// cycles in which a redirect was raised.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   pc_e, pc_plus4_e            PC and PC+4 of the instruction in execute
//   jump_e, branch_e            jal / beq control
//   result_src_e                writeback select (passed through)
//   mem_write_e, reg_write_e    store / register-write enables (passed through)
//   alu_src_e                   0: SrcB = forwarded rd2, 1: SrcB = imm_ext_e
//   alu_control_e               ALU operation
//   rd1_e, rd2_e, imm_ext_e     register operands and immediate
//   rd_e                        destination register
//   forward_a_e, forward_b_e    forwarding selects from the hazard unit
//   result_w                    writeback result (forwarding source)
//   pc_src_e, pc_target_e       combinational redirect request and target
//   *_m                         registered execute/memory pipeline outputs
//   redirect_cnt                number of clock edges with pc_src_e = 1
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic            jump_e,
    input  logic            branch_e,
    input  logic [1:0]      result_src_e,
    input  logic            mem_write_e,
    input  logic            reg_write_e,
    input  logic            alu_src_e,
    input  logic [2:0]      alu_control_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [4:0]      rd_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] redirect_cnt
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;
    logic            w_pc_src;

    logic            r_reg_write;
    logic            r_mem_write;
    logic [1:0]      r_result_src;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [XLEN-1:0] r_pc_plus4;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_redirect_cnt;

    // Forwarding mux for operand A; select 11 behaves like 00.
    always_comb begin
        w_src_a = rd1_e;
        case (forward_a_e)
            2'b01:   w_src_a = result_w;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = rd1_e;
        endcase
    end

    // Forwarding mux for operand B (also the store data); select 11 behaves like 00.
    always_comb begin
        w_fwd_b = rd2_e;
        case (forward_b_e)
            2'b01:   w_fwd_b = result_w;
            2'b10:   w_fwd_b = r_alu_result;
            default: w_fwd_b = rd2_e;
        endcase
    end

    // SrcB selection between forwarded register value and immediate.
    always_comb begin
        w_src_b = w_fwd_b;
        if (alu_src_e) begin
            w_src_b = imm_ext_e;
        end else begin
            w_src_b = w_fwd_b;
        end
    end

    // ALU; arithmetic wraps modulo 2^32, shift amount is SrcB[4:0].
    always_comb begin
        w_alu_result = 32'd0;
        case (alu_control_e)
            OP_ADD:  w_alu_result = w_src_a + w_src_b;
            OP_SUB:  w_alu_result = w_src_a - w_src_b;
            OP_AND:  w_alu_result = w_src_a & w_src_b;
            OP_OR:   w_alu_result = w_src_a | w_src_b;
            OP_XOR:  w_alu_result = w_src_a ^ w_src_b;
            OP_SLT:  w_alu_result = ($signed(w_src_a) < $signed(w_src_b)) ? 32'd1 : 32'd0;
            OP_SLL:  w_alu_result = w_src_a << w_src_b[4:0];
            OP_SRL:  w_alu_result = w_src_a >> w_src_b[4:0];
            default: w_alu_result = 32'd0;
        endcase
    end

    assign w_zero      = (w_alu_result == 32'd0);
    assign w_pc_src    = jump_e | (branch_e & w_zero);
    assign pc_src_e    = w_pc_src;
    assign pc_target_e = pc_e + imm_ext_e;

    // Execute/memory pipeline register; store data is the forwarded B, never the immediate.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_alu_result <= 32'd0;
            r_write_data <= 32'd0;
            r_pc_plus4   <= 32'd0;
            r_rd         <= 5'd0;
        end else begin
            r_reg_write  <= reg_write_e;
            r_mem_write  <= mem_write_e;
            r_result_src <= result_src_e;
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_b;
            r_pc_plus4   <= pc_plus4_e;
            r_rd         <= rd_e;
        end
    end

    // Redirect event counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_redirect_cnt <= 32'd0;
        end else if (w_pc_src) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end else begin
            r_redirect_cnt <= r_redirect_cnt;
        end
    end

    assign reg_write_m  = r_reg_write;
    assign mem_write_m  = r_mem_write;
    assign result_src_m = r_result_src;
    assign alu_result_m = r_alu_result;
    assign write_data_m = r_write_data;
    assign pc_plus4_m   = r_pc_plus4;
    assign rd_m         = r_rd;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32I pipeline, directly downstream of the decode stage. It consumes the decode/execute register outputs and resolves operand forwarding from the memory and writeback stages. It computes the ALU result and resolves branches and jumps, returning the redirect to fetch in the same cycle. It holds the execute/memory pipeline register and a redirect event counter.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous active-low reset
- pc_e, pc_plus4_e  in  32  PC and PC+4 of the instruction in execute
- jump_e, branch_e  in  1  jal, beq control
- result_src_e  in  2  writeback select, passed through
- mem_write_e, reg_write_e  in  1  store enable and register write enable, passed through
- alu_src_e  in  1  0: SrcB = forwarded rd2; 1: SrcB = imm_ext_e
- alu_control_e  in  3  ALU operation
- rd1_e, rd2_e, imm_ext_e  in  32  register operands and immediate
- rd_e  in  5  destination register
- forward_a_e, forward_b_e  in  2  forwarding selects from the hazard unit
- result_w  in  32  writeback result, used for forwarding
- pc_src_e  out  1  redirect fetch (combinational)
- pc_target_e  out  32  redirect target (combinational)
- reg_write_m, mem_write_m  out  1  registered controls
- result_src_m  out  2  registered control
- alu_result_m, write_data_m, pc_plus4_m  out  32  registered data
- rd_m  out  5  registered destination
- redirect_cnt  out  32  count of cycles with pc_src_e=1

## Operation
- Forwarding mux A/B:
  - 00: rd1_e/rd2_e.
  - 01: result_w.
  - 10: alu_result_m, fed back from this block's own register.
  - 11: treated as 00.
- SrcA = forwarded A. SrcB = alu_src_e ? imm_ext_e : forwarded B.
- ALU ops, with results truncated to 32 bits and wrap-around on overflow:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 slt: signed compare, result 1 or 0.
  - 110 sll.
  - 111 srl.
  - Shift amount is SrcB[4:0].
- zero = (alu_result == 0).
- pc_src_e = jump_e | (branch_e & zero).
- pc_target_e = pc_e + imm_ext_e, mod 2^32.
- write_data_m captures the forwarded B value, not the immediate.
- E/M register:
  - On each clk edge it captures reg_write, mem_write, result_src, alu_result, forwarded B, rd, and pc_plus4.
  - There is no stall or flush input. Bubbles arrive as all-zero decode outputs, which give reg_write=0 and mem_write=0.
- redirect_cnt: increments by 1 on each clk edge where pc_src_e=1. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset: assertion is asynchronous and forces every registered output and redirect_cnt to 0 immediately. Deassertion is honoured synchronously at the next clk edge.
- While arst_n=0, pc_src_e and pc_target_e still follow their inputs combinationally. redirect_cnt does not count during reset.
- Latency:
  - pc_src_e and pc_target_e: 0 cycles, valid in the same cycle as the decode outputs.
  - All *_m outputs: 1 cycle.
- Forwarding with 10 uses the value of alu_result_m present in the current cycle, i.e. the instruction one ahead.
- Simultaneous jump_e and branch_e: pc_src_e=1 and the counter increments by exactly 1.
- The same-cycle flush of decode on pc_src_e is the hazard unit's job. This block only reports pc_src_e.
- Reset asserted mid-operation: in-flight E/M contents are discarded. The first instruction after deassertion is captured normally.

## Test plan
- Plain add:
  - Stimulus: rd1_e=5, rd2_e=7, alu_src_e=0, alu_control_e=000, reg_write_e=1, rd_e=3, forwards=00.
  - Response: next cycle alu_result_m=12, rd_m=3, reg_write_m=1, write_data_m=7.
- Forward from M:
  - Stimulus: cycle 1 computes 10+20, so alu_result_m=30 in cycle 2. In cycle 2, forward_a_e=10, rd1_e=0, imm_ext_e=4, alu_src_e=1, op 000.
  - Response: alu_result_m=34 in cycle 3.
- Forward from W:
  - Stimulus: forward_b_e=01, result_w=0xFFFF_FFFF, rd1_e=1, op 001.
  - Response: alu_result_m=2, write_data_m=0xFFFF_FFFF.
- Branch taken:
  - Stimulus: branch_e=1, rd1_e=rd2_e=9, op 001, pc_e=0x100, imm_ext_e=0xFFFF_FFF8.
  - Response: same cycle pc_src_e=1, pc_target_e=0xF8. redirect_cnt goes 0→1.
- Branch not taken and jump:
  - Stimulus: branch with rd1=1, rd2=2 gives pc_src_e=0 and the counter is unchanged. Then jump_e=1, pc_plus4_e=0x104.
  - Response: pc_src_e=1, pc_plus4_m=0x104.
- Signed slt, shifts and reset:
  - slt with 0x8000_0000 vs 1 gives 1.
  - srl of 0x8000_0000 by 31 gives 1.
  - Drop arst_n mid-clock with non-zero *_m: all outputs go to 0 immediately, before any clk edge.
